// File: rtl/decode_stage_if.sv
// Bus bundle between the decode stage, the fetch instruction queue,
// the redirect source and the rename/dispatch consumer.
interface decode_stage_if;
  logic [31:0] iq_rdata;
  logic        iq_empty;
  logic        iq_dequeue;
  logic        flush;
  logic [31:0] flush_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_uses_rs1;
  logic        out_uses_rs2;
  logic        out_writes_rd;
  logic        out_illegal;

  // The decode stage itself
  modport master (
    input  iq_rdata, iq_empty, flush, flush_pc, out_ready,
    output iq_dequeue, out_valid, out_pc, out_inst, out_opcode, out_rd,
           out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
           out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal
  );

  // The surrounding queue / redirect / consumer logic
  modport slave (
    output iq_rdata, iq_empty, flush, flush_pc, out_ready,
    input  iq_dequeue, out_valid, out_pc, out_inst, out_opcode, out_rd,
           out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
           out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: pops one word per cycle from the instruction queue,
// tags it with a locally tracked PC, decodes it and holds the result in a
// single valid/ready output register.
module decode_stage #(
  parameter logic [31:0] RESET_PC    = 32'h1eceb000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  decode_stage_if.master         bus,
  output logic [COUNT_WIDTH-1:0] decoded_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc_reg;
  logic [31:0] inst;
  logic [31:0] dec_imm;
  logic        dec_uses_rs1;
  logic        dec_uses_rs2;
  logic        dec_writes_class;
  logic        dec_writes_rd;
  logic        dec_illegal;

  assign inst = bus.iq_rdata;

  // Pop the queue head whenever the output register is free or being drained
  assign bus.iq_dequeue = !rst && !bus.flush && !bus.iq_empty &&
                          (!bus.out_valid || bus.out_ready);

  // Immediate and flag decode of the word at the queue head
  always_comb begin
    dec_imm          = 32'h0;
    dec_uses_rs1     = 1'b0;
    dec_uses_rs2     = 1'b0;
    dec_writes_class = 1'b0;
    dec_illegal      = 1'b0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_imm          = {{20{inst[31]}}, inst[31:20]};
        dec_uses_rs1     = 1'b1;
        dec_writes_class = 1'b1;
      end
      OP_STORE: begin
        dec_imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                        inst[11:8], 1'b0};
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm          = {inst[31:12], 12'h000};
        dec_writes_class = 1'b1;
      end
      OP_JAL: begin
        dec_imm          = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
        dec_writes_class = 1'b1;
      end
      OP_REG: begin
        dec_uses_rs1     = 1'b1;
        dec_uses_rs2     = 1'b1;
        dec_writes_class = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
    dec_writes_rd = dec_writes_class && (inst[11:7] != 5'd0);
  end

  // Output register, PC tracker and counter: reset, flush, load, drain, hold
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.out_pc        <= 32'h0;
      bus.out_inst      <= 32'h0;
      bus.out_opcode    <= 7'h0;
      bus.out_rd        <= 5'h0;
      bus.out_rs1       <= 5'h0;
      bus.out_rs2       <= 5'h0;
      bus.out_funct3    <= 3'h0;
      bus.out_funct7    <= 7'h0;
      bus.out_imm       <= 32'h0;
      bus.out_uses_rs1  <= 1'b0;
      bus.out_uses_rs2  <= 1'b0;
      bus.out_writes_rd <= 1'b0;
      bus.out_illegal   <= 1'b0;
      pc_reg            <= RESET_PC;
      decoded_count     <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      pc_reg        <= bus.flush_pc;
    end else if (bus.iq_dequeue) begin
      bus.out_valid     <= 1'b1;
      bus.out_pc        <= pc_reg;
      bus.out_inst      <= inst;
      bus.out_opcode    <= inst[6:0];
      bus.out_rd        <= inst[11:7];
      bus.out_rs1       <= inst[19:15];
      bus.out_rs2       <= inst[24:20];
      bus.out_funct3    <= inst[14:12];
      bus.out_funct7    <= inst[31:25];
      bus.out_imm       <= dec_imm;
      bus.out_uses_rs1  <= dec_uses_rs1;
      bus.out_uses_rs2  <= dec_uses_rs2;
      bus.out_writes_rd <= dec_writes_rd;
      bus.out_illegal   <= dec_illegal;
      pc_reg            <= pc_reg + 32'd4;
      decoded_count     <= decoded_count + COUNT_WIDTH'(1);
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
